// File: rtl/dm_arb_pkg.sv
// Shared types and limits for the data-memory port arbiter.
package dm_arb_pkg;

  localparam int unsigned MAX_RD_LATENCY = 3;

  typedef enum logic {ARB_IDLE, ARB_SERVE_P1} arb_state_t;

  typedef enum logic [1:0] {OWN_NONE, OWN_P0, OWN_P1, OWN_BOTH} rd_owner_t;

  function automatic logic owns_p0(input rd_owner_t own);
    return (own == OWN_P0) || (own == OWN_BOTH);
  endfunction

  function automatic logic owns_p1(input rd_owner_t own);
    return (own == OWN_P1) || (own == OWN_BOTH);
  endfunction

endpackage

// File: rtl/dm_arb_tag_pipe.sv
// Read-owner delay line: one stage per cycle of memory read latency.
module dm_arb_tag_pipe
  import dm_arb_pkg::*;
#(
  parameter int unsigned RD_LATENCY = 1
) (
  input  logic      clk,
  input  logic      rst,
  input  rd_owner_t owner_i,
  output rd_owner_t owner_o
);

  rd_owner_t stage_q [RD_LATENCY];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < RD_LATENCY; i++) stage_q[i] <= OWN_NONE;
    end else begin
      stage_q[0] <= owner_i;
      for (int unsigned i = 1; i < RD_LATENCY; i++) stage_q[i] <= stage_q[i-1];
    end
  end

  assign owner_o = stage_q[RD_LATENCY-1];

endmodule

// File: rtl/dm_port_arbiter.sv
// Serialises the two pipelines' data-memory ports onto one single-port memory.
// Optional build macro DM_ARB_READ_MERGE_EN merges same-address dual loads.
module dm_port_arbiter
  import dm_arb_pkg::*;
#(
  parameter int unsigned ADDR_W     = 9,
  parameter int unsigned DATA_W     = 16,
  parameter int unsigned RD_LATENCY = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              p0_req,
  input  logic              p0_write,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic [DATA_W-1:0] p0_wdata,
  output logic              p0_rvalid,
  output logic [DATA_W-1:0] p0_rdata,
  input  logic              p1_req,
  input  logic              p1_write,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [DATA_W-1:0] p1_wdata,
  output logic              p1_rvalid,
  output logic [DATA_W-1:0] p1_rdata,
  input  logic              flush_p1,
  output logic              stall,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_write,
  input  logic [DATA_W-1:0] mem_rdata
);

  arb_state_t        state_q, state_d;
  rd_owner_t         issue_own, ret_own;
  logic [DATA_W-1:0] p0_rdata_q, p1_rdata_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ARB_IDLE;
    else     state_q <= state_d;
  end

  // Reset gates every strobe combinationally so nothing reaches memory while rst is high.
  always_comb begin
    state_d   = state_q;
    stall     = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_write = 1'b0;
    issue_own = OWN_NONE;
    if (!rst) begin
      case (state_q)
        ARB_IDLE: begin
          if (p0_req) begin
            mem_addr  = p0_addr;
            mem_wdata = p0_wdata;
            mem_write = p0_write;
            issue_own = p0_write ? OWN_NONE : OWN_P0;
            if (p1_req) begin
`ifdef DM_ARB_READ_MERGE_EN
              if (!p0_write && !p1_write && (p0_addr == p1_addr)) begin
                issue_own = OWN_BOTH;
              end else begin
                stall   = 1'b1;
                state_d = ARB_SERVE_P1;
              end
`else
              stall   = 1'b1;
              state_d = ARB_SERVE_P1;
`endif
            end
          end else if (p1_req) begin
            mem_addr  = p1_addr;
            mem_wdata = p1_wdata;
            mem_write = p1_write;
            issue_own = p1_write ? OWN_NONE : OWN_P1;
          end
        end
        ARB_SERVE_P1: begin
          state_d = ARB_IDLE;
          if (!flush_p1 && p1_req) begin
            mem_addr  = p1_addr;
            mem_wdata = p1_wdata;
            mem_write = p1_write;
            issue_own = p1_write ? OWN_NONE : OWN_P1;
          end
        end
        default: state_d = ARB_IDLE;
      endcase
    end
  end

  dm_arb_tag_pipe #(
    .RD_LATENCY(RD_LATENCY)
  ) u_tag_pipe (
    .clk    (clk),
    .rst    (rst),
    .owner_i(issue_own),
    .owner_o(ret_own)
  );

  assign p0_rvalid = owns_p0(ret_own);
  assign p1_rvalid = owns_p1(ret_own);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      p0_rdata_q <= '0;
      p1_rdata_q <= '0;
    end else begin
      if (p0_rvalid) p0_rdata_q <= mem_rdata;
      if (p1_rvalid) p1_rdata_q <= mem_rdata;
    end
  end

  // Fresh data bypasses the holding register in the return cycle.
  assign p0_rdata = p0_rvalid ? mem_rdata : p0_rdata_q;
  assign p1_rdata = p1_rvalid ? mem_rdata : p1_rdata_q;

endmodule
